// File: rtl/hynoc_local_ingress_fifo_if.sv
// ---------------------------------------------------------------------------
// hynoc_local_ingress_fifo_if
// Bundles the write side (from hynoc_stream_writer) and the egress side
// (towards the router local input port) of the local ingress buffer.
//   master : the environment (stream writer + router) driving writes/ready
//   slave  : the ingress FIFO itself
// Signals:
//   local_ingress_write       write strobe
//   local_ingress_data        flit to store, MSB = end-of-packet
//   local_ingress_fifo_level  registered occupancy 0..DEPTH
//   local_ingress_overflow    sticky dropped-write flag
//   egress_valid/ready/data   first-word fall-through head flit handshake
//   egress_pkt_done           one-cycle pulse per accepted end-of-packet flit
// ---------------------------------------------------------------------------
interface hynoc_local_ingress_fifo_if #(
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1
);
  logic                    local_ingress_write;
  logic [FLIT_WIDTH-1:0]   local_ingress_data;
  logic [LOG2_FIFO_DEPTH:0] local_ingress_fifo_level;
  logic                    local_ingress_overflow;
  logic                    egress_valid;
  logic [FLIT_WIDTH-1:0]   egress_data;
  logic                    egress_ready;
  logic                    egress_pkt_done;

  modport master (
    output local_ingress_write, local_ingress_data, egress_ready,
    input  local_ingress_fifo_level, local_ingress_overflow,
           egress_valid, egress_data, egress_pkt_done
  );

  modport slave (
    input  local_ingress_write, local_ingress_data, egress_ready,
    output local_ingress_fifo_level, local_ingress_overflow,
           egress_valid, egress_data, egress_pkt_done
  );
endinterface

// File: rtl/hynoc_local_ingress_fifo.sv
// ---------------------------------------------------------------------------
// hynoc_local_ingress_fifo
// Local ingress buffer between hynoc_stream_writer and the router local
// input port. DEPTH = 2**LOG2_FIFO_DEPTH flits, first-word fall-through.
// Flit MSB marks end-of-packet.
// Ports:
//   local_clk   clock, rising edge
//   local_srst  asynchronous active-high reset
//   bus         hynoc_local_ingress_fifo_if.slave (write side + egress side)
// Optional build macro:
//   HYNOC_INGRESS_STORE_AND_FORWARD_EN - hold egress until a whole packet is
//   buffered (with a full-buffer cut-through fallback for long packets).
// ---------------------------------------------------------------------------
module hynoc_local_ingress_fifo #(
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FLIT_WIDTH      = PAYLOAD_WIDTH + 1
) (
  input logic                     local_clk,
  input logic                     local_srst,
  hynoc_local_ingress_fifo_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam int LW    = LOG2_FIFO_DEPTH + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [FLIT_WIDTH-1:0]      mem_q [DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       overflow_q, overflow_d;
  logic                       pkt_done_q, pkt_done_d;

  logic                  full, valid, wr_acc, rd_acc;
  logic [FLIT_WIDTH-1:0] head;

  assign head   = mem_q[rd_ptr_q];
  assign full   = (level_q == FULL_LVL);
  // Full is judged on the registered level: a same-cycle read does not
  // make room for a write.
  assign wr_acc = bus.local_ingress_write && !full;
  assign rd_acc = valid && bus.egress_ready;

`ifdef HYNOC_INGRESS_STORE_AND_FORWARD_EN
  logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          in_pkt_q, in_pkt_d;   // a packet has started leaving
  logic          eop_wr, eop_rd;

  assign eop_wr = wr_acc && bus.local_ingress_data[FLIT_WIDTH-1];
  assign eop_rd = rd_acc && head[FLIT_WIDTH-1];

  // Full-buffer term lets packets longer than DEPTH cut through; in_pkt
  // keeps such a packet flowing once it has started.
  assign valid = (level_q != '0) && ((pkt_cnt_q != '0) || full || in_pkt_q);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({eop_wr, eop_rd})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    in_pkt_d = rd_acc ? !head[FLIT_WIDTH-1] : in_pkt_q;
  end

  always_ff @(posedge local_clk or posedge local_srst) begin
    if (local_srst) begin
      pkt_cnt_q <= '0;
      in_pkt_q  <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      in_pkt_q  <= in_pkt_d;
    end
  end
`else
  assign valid = (level_q != '0);
`endif

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q || (bus.local_ingress_write && full);
    pkt_done_d = rd_acc && head[FLIT_WIDTH-1];
  end

  always_ff @(posedge local_clk or posedge local_srst) begin
    if (local_srst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Storage is never reset; stale contents are masked by egress_valid.
  always_ff @(posedge local_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.local_ingress_data;
  end

  assign bus.egress_valid             = valid;
  assign bus.egress_data              = head;
  assign bus.local_ingress_fifo_level = level_q;
  assign bus.local_ingress_overflow   = overflow_q;
  assign bus.egress_pkt_done          = pkt_done_q;
endmodule

// File: tb/tb_hynoc_local_ingress_fifo.sv
module tb_hynoc_local_ingress_fifo;
  localparam int L     = 5;
  localparam int PW    = 32;
  localparam int FW    = PW + 1;
  localparam int DEPTH = 1 << L;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hynoc_local_ingress_fifo_if #(.LOG2_FIFO_DEPTH(L), .PAYLOAD_WIDTH(PW), .FLIT_WIDTH(FW)) bus ();

  hynoc_local_ingress_fifo #(.LOG2_FIFO_DEPTH(L), .PAYLOAD_WIDTH(PW), .FLIT_WIDTH(FW)) dut (
    .local_clk  (clk),
    .local_srst (rst),
    .bus        (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the buffer is a queue of flits in arrival order.
  logic [FW-1:0] mq[$];
  bit m_ovf, m_done, m_inpkt;
  int n_out;

  function automatic bit m_valid();
`ifdef HYNOC_INGRESS_STORE_AND_FORWARD_EN
    int eops = 0;
    foreach (mq[i]) if (mq[i][FW-1]) eops++;
    return (mq.size() != 0) && (eops != 0 || mq.size() == DEPTH || m_inpkt);
`else
    return (mq.size() != 0) || (m_inpkt && 1'b0);
`endif
  endfunction

  task automatic tick(input bit wr, input logic [FW-1:0] d, input bit rdy);
    bit v, wa, ra;
    logic [FW-1:0] head;
    bus.local_ingress_write = wr;
    bus.local_ingress_data  = d;
    bus.egress_ready        = rdy;
    v    = m_valid();
    wa   = wr && (mq.size() != DEPTH);
    ra   = v && rdy;
    head = (mq.size() != 0) ? mq[0] : '0;
    if (wr && !wa) m_ovf = 1'b1;
    m_done = ra && head[FW-1];
    if (ra) begin
      void'(mq.pop_front());
      n_out++;
      m_inpkt = !head[FW-1];
    end
    if (wa) mq.push_back(d);
    @(posedge clk); #1;
    bus.local_ingress_write = 1'b0;
    bus.egress_ready        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 0; m_done = 0; m_inpkt = 0; n_out = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.local_ingress_fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.local_ingress_fifo_level); end
    n_chk++; if (bus.egress_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.egress_valid); end
    n_chk++; if (bus.local_ingress_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.local_ingress_overflow); end
    n_chk++; if (bus.egress_pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done: got %b expected 0", bus.egress_pkt_done); end
    rst = 1'b0;
    mq.delete();
    m_ovf = 0; m_done = 0; m_inpkt = 0; n_out = 0;
  endtask

  task automatic test_single();
    do_reset();
    tick(1'b1, 33'h1DEADBEEF, 1'b1);
    n_chk++; if (bus.local_ingress_fifo_level !== 6'd1) begin n_fail++; $display("FAIL single_level: got %0d expected 1", bus.local_ingress_fifo_level); end
    n_chk++; if (bus.egress_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.egress_valid); end
    n_chk++; if (bus.egress_data !== 33'h1DEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected 1deadbeef", bus.egress_data); end
    tick(1'b0, '0, 1'b1);
    n_chk++; if (bus.local_ingress_fifo_level !== 6'd0) begin n_fail++; $display("FAIL single_level_after: got %0d expected 0", bus.local_ingress_fifo_level); end
    n_chk++; if (bus.egress_pkt_done !== 1'b1) begin n_fail++; $display("FAIL single_pkt_done: got %b expected 1", bus.egress_pkt_done); end
    n_chk++; if (bus.egress_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b expected 0", bus.egress_valid); end
  endtask

  task automatic test_fill_overflow();
    logic [FW-1:0] sent[DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      sent[i] = {(i == DEPTH - 1) ? 1'b1 : 1'($urandom), 32'($urandom)};
      tick(1'b1, sent[i], 1'b0);
      n_chk++; if (bus.local_ingress_fifo_level !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", bus.local_ingress_fifo_level, i + 1); end
    end
    n_chk++; if (bus.local_ingress_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_overflow: got %b expected 0", bus.local_ingress_overflow); end
    tick(1'b1, {1'b0, 32'hBAD0BAD0}, 1'b0);
    n_chk++; if (bus.local_ingress_fifo_level !== 6'(DEPTH)) begin n_fail++; $display("FAIL overflow_level: got %0d expected %0d", bus.local_ingress_fifo_level, DEPTH); end
    n_chk++; if (bus.local_ingress_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_flag: got %b expected 1", bus.local_ingress_overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++; if (bus.egress_valid !== 1'b1 || bus.egress_data !== sent[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got v=%b %h expected v=1 %h", i, bus.egress_valid, bus.egress_data, sent[i]); end
      tick(1'b0, '0, 1'b1);
      n_chk++; if (bus.egress_pkt_done !== sent[i][FW-1]) begin n_fail++; $display("FAIL drain_pkt_done[%0d]: got %b expected %b", i, bus.egress_pkt_done, sent[i][FW-1]); end
      n_chk++; if (bus.local_ingress_fifo_level !== 6'(DEPTH - 1 - i)) begin n_fail++; $display("FAIL drain_level: got %0d expected %0d", bus.local_ingress_fifo_level, DEPTH - 1 - i); end
    end
    n_chk++; if (bus.local_ingress_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", bus.local_ingress_overflow); end
    n_chk++; if (bus.egress_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", bus.egress_valid); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, {1'(i), 32'($urandom)}, 1'b0);
    n_chk++; if (bus.local_ingress_fifo_level !== 6'd5) begin n_fail++; $display("FAIL stream_prefill: got %0d expected 5", bus.local_ingress_fifo_level); end
    for (int c = 0; c < 100; c++) begin
      n_chk++; if (bus.egress_valid !== 1'b1 || bus.egress_data !== mq[0]) begin n_fail++; $display("FAIL stream_data[%0d]: got v=%b %h expected v=1 %h", c, bus.egress_valid, bus.egress_data, mq[0]); end
      tick(1'b1, {1'(c), 32'($urandom)}, 1'b1);
      n_chk++; if (bus.local_ingress_fifo_level !== 6'd5) begin n_fail++; $display("FAIL stream_level[%0d]: got %0d expected 5", c, bus.local_ingress_fifo_level); end
      n_chk++; if (bus.egress_pkt_done !== m_done) begin n_fail++; $display("FAIL stream_pkt_done[%0d]: got %b expected %b", c, bus.egress_pkt_done, m_done); end
    end
    n_chk++; if (n_out !== 100) begin n_fail++; $display("FAIL stream_count: got %0d expected 100", n_out); end
  endtask

  task automatic test_random_packets();
    logic [FW-1:0] src[$];
    int total, dones, cyc;
    bit wr, rdy;
    do_reset();
    for (int p = 0; p < 100; p++) begin
      int len = int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++) src.push_back({(j == len - 1), 32'($urandom)});
    end
    total = src.size();
    dones = 0;
    cyc   = 0;
    while ((src.size() != 0 || mq.size() != 0) && cyc < 20000) begin
      wr  = (src.size() != 0) && (bus.local_ingress_fifo_level != 6'(DEPTH)) && ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom);
      if (m_valid()) begin
        n_chk++; if (bus.egress_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data: got %h expected %h", bus.egress_data, mq[0]); end
      end
      tick(wr, wr ? src[0] : '0, rdy);
      if (wr) void'(src.pop_front());
      cyc++;
      if (bus.egress_pkt_done === 1'b1) dones++;
      n_chk++; if (bus.local_ingress_fifo_level !== 6'(mq.size())) begin n_fail++; $display("FAIL rnd_level: got %0d expected %0d", bus.local_ingress_fifo_level, mq.size()); end
      n_chk++; if (bus.egress_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid: got %b expected %b", bus.egress_valid, m_valid()); end
      n_chk++; if (bus.egress_pkt_done !== m_done) begin n_fail++; $display("FAIL rnd_pkt_done: got %b expected %b", bus.egress_pkt_done, m_done); end
    end
    n_chk++; if (cyc >= 20000) begin n_fail++; $display("FAIL rnd_timeout: got %0d cycles expected under 20000", cyc); end
    n_chk++; if (bus.local_ingress_overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_overflow: got %b expected 0", bus.local_ingress_overflow); end
    n_chk++; if (dones !== 100) begin n_fail++; $display("FAIL rnd_pkt_count: got %0d expected 100", dones); end
    n_chk++; if (n_out !== total) begin n_fail++; $display("FAIL rnd_flit_count: got %0d expected %0d", n_out, total); end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] a[3];
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, {1'b0, 32'($urandom)}, 1'b0);
    n_chk++; if (bus.local_ingress_fifo_level !== 6'd7) begin n_fail++; $display("FAIL mid_level7: got %0d expected 7", bus.local_ingress_fifo_level); end
    rst = 1'b1;
    #1;
    n_chk++; if (bus.local_ingress_fifo_level !== '0) begin n_fail++; $display("FAIL mid_rst_level: got %0d expected 0", bus.local_ingress_fifo_level); end
    n_chk++; if (bus.egress_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", bus.egress_valid); end
    n_chk++; if (bus.local_ingress_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overflow: got %b expected 0", bus.local_ingress_overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_ovf = 0; m_done = 0; m_inpkt = 0; n_out = 0;
    for (int i = 0; i < 3; i++) begin
      a[i] = {1'b1, 32'($urandom)};
      tick(1'b1, a[i], 1'b0);
    end
    n_chk++; if (bus.local_ingress_fifo_level !== 6'd3) begin n_fail++; $display("FAIL mid_after_level: got %0d expected 3", bus.local_ingress_fifo_level); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.egress_valid !== 1'b1 || bus.egress_data !== a[i]) begin n_fail++; $display("FAIL mid_after_data[%0d]: got v=%b %h expected v=1 %h", i, bus.egress_valid, bus.egress_data, a[i]); end
      tick(1'b0, '0, 1'b1);
    end
    n_chk++; if (bus.local_ingress_fifo_level !== 6'd0) begin n_fail++; $display("FAIL mid_after_empty: got %0d expected 0", bus.local_ingress_fifo_level); end
  endtask

`ifdef HYNOC_INGRESS_STORE_AND_FORWARD_EN
  task automatic test_store_forward();
    logic [FW-1:0] src[$];
    int cyc, dones;
    bit seen_valid, wr;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, {1'b0, 32'($urandom)}, 1'b0);
      n_chk++; if (bus.egress_valid !== 1'b0) begin n_fail++; $display("FAIL saf_hold[%0d]: got %b expected 0", i, bus.egress_valid); end
    end
    tick(1'b1, {1'b1, 32'($urandom)}, 1'b0);
    n_chk++; if (bus.egress_valid !== 1'b1) begin n_fail++; $display("FAIL saf_release: got %b expected 1", bus.egress_valid); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.egress_valid !== 1'b1 || bus.egress_data !== mq[0]) begin n_fail++; $display("FAIL saf_data[%0d]: got v=%b %h expected v=1 %h", i, bus.egress_valid, bus.egress_data, mq[0]); end
      tick(1'b0, '0, 1'b1);
    end
    for (int j = 0; j < 40; j++) src.push_back({(j == 39), 32'($urandom)});
    cyc = 0; dones = 0; seen_valid = 0;
    n_out = 0;
    while ((src.size() != 0 || mq.size() != 0) && cyc < 500) begin
      wr = (src.size() != 0) && (bus.local_ingress_fifo_level != 6'(DEPTH));
      if (!seen_valid) begin
        n_chk++; if (bus.egress_valid !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL saf_long_hold: got %b at level %0d", bus.egress_valid, mq.size()); end
        if (mq.size() == DEPTH) seen_valid = 1;
      end else begin
        n_chk++; if (bus.egress_valid !== 1'b1 || bus.egress_data !== mq[0]) begin n_fail++; $display("FAIL saf_long_flow: got v=%b %h expected v=1 %h", bus.egress_valid, bus.egress_data, mq[0]); end
      end
      tick(wr, wr ? src[0] : '0, 1'b1);
      if (wr) void'(src.pop_front());
      if (bus.egress_pkt_done === 1'b1) dones++;
      cyc++;
    end
    n_chk++; if (cyc >= 500) begin n_fail++; $display("FAIL saf_long_timeout: got %0d cycles expected under 500", cyc); end
    n_chk++; if (n_out !== 40 || dones !== 1) begin n_fail++; $display("FAIL saf_long_count: got %0d flits %0d done expected 40 flits 1 done", n_out, dones); end
    n_chk++; if (bus.local_ingress_overflow !== 1'b0) begin n_fail++; $display("FAIL saf_long_overflow: got %b expected 0", bus.local_ingress_overflow); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.local_ingress_write = 1'b0;
    bus.local_ingress_data  = '0;
    bus.egress_ready        = 1'b0;
    m_ovf = 0; m_done = 0; m_inpkt = 0; n_out = 0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_streaming();
    test_random_packets();
    test_reset_mid();
`ifdef HYNOC_INGRESS_STORE_AND_FORWARD_EN
    test_store_forward();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hynoc_local_ingress_fifo.md
Name: hynoc_local_ingress_fifo

Overview:
Local ingress buffer that sits directly downstream of hynoc_stream_writer. It takes flits written through the local_ingress_write/local_ingress_data interface and reports occupancy back on local_ingress_fifo_level. It presents buffered flits to the router local input port through a valid/ready handshake. Flit MSB (bit FLIT_WIDTH-1) is the end-of-packet marker; the lower PAYLOAD_WIDTH bits carry the payload.

Parameters:
LOG2_FIFO_DEPTH, 5, log2 of buffer depth; DEPTH = 2**LOG2_FIFO_DEPTH flits
PAYLOAD_WIDTH, 32, payload bits per flit
FLIT_WIDTH, PAYLOAD_WIDTH+1, flit width including the end-of-packet bit

Ports:
local_clk  in  1  single clock; all logic on its rising edge
local_srst  in  1  reset; asynchronous, active-high
local_ingress_write  in  1  write strobe from the stream writer
local_ingress_data  in  FLIT_WIDTH  flit to store
local_ingress_fifo_level  out  LOG2_FIFO_DEPTH+1  registered occupancy, 0..DEPTH
local_ingress_overflow  out  1  sticky flag: a write was dropped because the buffer was full
egress_valid  out  1  flit available at egress_data
egress_data  out  FLIT_WIDTH  head flit (first-word fall-through)
egress_ready  in  1  router accepts the head flit
egress_pkt_done  out  1  one-cycle pulse on each accepted flit whose MSB = 1

Behaviour:
- Reset (asynchronous on local_srst = 1) sets:
  - wr_ptr = 0, rd_ptr = 0 (each LOG2_FIFO_DEPTH bits, wrap naturally).
  - level = 0, overflow = 0, egress_valid = 0, egress_pkt_done = 0.
  - Memory contents are not reset; egress_data is don't-care while egress_valid = 0.
- Storage: DEPTH x FLIT_WIDTH register array.
  - egress_data = mem[rd_ptr], combinational from registered state.
- Write accept: local_ingress_write && (level != DEPTH), using the registered level.
  - A write is refused when level == DEPTH, even if a read happens in the same cycle.
  - The stream writer throttles on level, so the refused case is an error: the flit is dropped and overflow is set, held until reset.
- Read accept: egress_valid && egress_ready. egress_ready while egress_valid = 0 has no effect.
- Level update, next cycle:
  - +1 on write only.
  - -1 on read only.
  - unchanged on simultaneous write and read, or on neither.
  - Level never wraps; the 0..DEPTH range is guaranteed by the accept rules.
- Latency:
  - A write into an empty buffer gives egress_valid = 1 on the next cycle, with egress_data equal to that flit.
  - local_ingress_fifo_level reflects the write on the same edge.
- egress_valid = (level != 0), unless the optional feature below is enabled.
- egress_pkt_done: registered; pulses the cycle after an accepted read whose flit MSB = 1.
- Pointer wrap: wr_ptr and rd_ptr go from DEPTH-1 to 0; ordering is preserved across the wrap.
- Flits leave in strict arrival order. No flit is ever duplicated or reordered.
- Reset mid-packet: contents are discarded and the partial packet is lost. Upstream is expected to be reset together with this block.

Optional Feature:
Macro HYNOC_INGRESS_STORE_AND_FORWARD_EN.
- Defined:
  - Adds a counter pkt_cnt of LOG2_FIFO_DEPTH+1 bits, reset to 0.
  - pkt_cnt +1 on an accepted write with MSB = 1, -1 on an accepted read with MSB = 1, unchanged when both or neither occur.
  - egress_valid = (level != 0) && ((pkt_cnt != 0) || (level == DEPTH)). The full-buffer term is a cut-through fallback for packets longer than DEPTH, to avoid deadlock.
  - Once the first flit of a packet is accepted, egress_valid stays asserted until that packet's last flit leaves, provided flits remain stored.
- Undefined: pure cut-through; pkt_cnt is absent.

Test Plan:
- Reset, then a single write of {1'b1, 32'hDEADBEEF} with egress_ready = 1 -> next cycle level = 1, egress_valid = 1, egress_data = 33'h1DEADBEEF. Cycle after: level = 0, egress_pkt_done = 1.
- 32 writes with egress_ready = 0 -> level = 32. A 33rd write -> level stays 32, overflow = 1 and stays 1. Then drain 32 -> data matches the first 32 flits in order.
- Streaming: simultaneous write and read every cycle for 100 cycles from level = 5 -> level stays 5, pointers wrap at least 3 times, output sequence equals input sequence.
- Random egress_ready (50%), driven by a hynoc_stream_writer model with 100 packets of random length -> zero overflow, all flits in order, egress_pkt_done count = 100.
- Assert local_srst mid-packet at level = 7 -> immediately level = 0, egress_valid = 0, overflow = 0. Afterwards, new writes are accepted normally.
- With HYNOC_INGRESS_STORE_AND_FORWARD_EN: write 3 flits with MSB = 0 -> egress_valid = 0. Write a 4th with MSB = 1 -> egress_valid = 1 next cycle. A 40-flit packet with egress_ready = 1 -> egress_valid rises once level = 32 and the packet drains fully.
